// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program counter / sequencer stage.
// Branch targets live here so programs only change this file.
package pc_unit_pkg;

  localparam int PC_W      = 10;
  localparam int LUT_AW    = 5;
  localparam int LUT_DEPTH = 1 << LUT_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } PcState;

  // Absolute PC_W-bit targets; unused entries are zero
  localparam logic [PC_W-1:0] BRANCH_TARGETS [0:LUT_DEPTH-1] = '{
    10'd0,   10'd5,   10'd7,   10'd40,
    10'd12,  10'd0,   10'd0,   10'd1023,
    10'd0,   10'd100, 10'd0,   10'd0,
    10'd0,   10'd0,   10'd0,   10'd0,
    10'd0,   10'd513, 10'd0,   10'd0,
    10'd0,   10'd0,   10'd0,   10'd0,
    10'd0,   10'd0,   10'd0,   10'd0,
    10'd0,   10'd0,   10'd0,   10'd1
  };

endpackage

// File: rtl/pc_unit_branch_lut.sv
// Combinational branch-target lookup.
// Indexes the package target table with the instruction field.
module branch_lut
  import pc_unit_pkg::*;
(
  input  logic [LUT_AW-1:0] target_sel,
  output logic [PC_W-1:0]   target
);

  assign target = BRANCH_TARGETS[target_sel];

endmodule

// File: rtl/pc_unit.sv
// Program counter and start/run/halt sequencer.
// Optional PC_CYCLE_COUNT_EN adds a saturating RUN-cycle counter.
module pc_unit
  import pc_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_in,
  input  logic              halt_in,
  input  logic              jump_in,
  input  logic              branch_in,
  input  logic [7:0]        cond_in,
  input  logic [LUT_AW-1:0] target_sel,
  output logic [PC_W-1:0]   pc_out,
  output logic              done_out
`ifdef PC_CYCLE_COUNT_EN
  ,
  output logic [15:0]       cycle_cnt_out
`endif
);

  PcState          state, state_nx;
  logic [PC_W-1:0] pc_nx;
  logic            done_nx;
  logic [PC_W-1:0] target;

  branch_lut u_lut (
    .target_sel (target_sel),
    .target     (target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc_out   <= '0;
      done_out <= 1'b0;
    end else begin
      state    <= state_nx;
      pc_out   <= pc_nx;
      done_out <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_out;
    done_nx  = done_out;
    unique case (state)
      IDLE: begin
        pc_nx   = '0;
        done_nx = 1'b0;
        if (start_in) state_nx = RUN;
      end
      RUN: begin
        done_nx = 1'b0;
        if (halt_in) begin
          state_nx = HALT;
          done_nx  = 1'b1;
        end else if (jump_in) begin
          pc_nx = target;
        end else if (branch_in && cond_in != 8'd0) begin
          pc_nx = target;
        end else begin
          pc_nx = pc_out + PC_W'(1);
        end
      end
      HALT: begin
        done_nx = 1'b1;
        if (start_in) begin
          state_nx = RUN;
          pc_nx    = '0;
          done_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        pc_nx    = '0;
        done_nx  = 1'b0;
      end
    endcase
  end

`ifdef PC_CYCLE_COUNT_EN
  // Restart clears; the count of a halted program stays readable
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_out <= '0;
    end else if (state != RUN && state_nx == RUN) begin
      cycle_cnt_out <= '0;
    end else if (state == RUN && cycle_cnt_out != 16'hFFFF) begin
      cycle_cnt_out <= cycle_cnt_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed steps then random traffic
// compared against a rule-level reference model.
module tb_pc_unit;

  logic       clk = 1'b0;
  logic       reset, start_in, halt_in, jump_in, branch_in;
  logic [7:0] cond_in;
  logic [4:0] target_sel;
  logic [9:0] pc_out;
  logic       done_out;
`ifdef PC_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt_out;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: 0 idle, 1 running, 2 halted
  int          m_mode;
  int          m_pc;
  bit          m_done;
  int          m_cnt;
  int          lut [32];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start_in   (start_in),
    .halt_in    (halt_in),
    .jump_in    (jump_in),
    .branch_in  (branch_in),
    .cond_in    (cond_in),
    .target_sel (target_sel),
    .pc_out     (pc_out),
    .done_out   (done_out)
`ifdef PC_CYCLE_COUNT_EN
    ,
    .cycle_cnt_out (cycle_cnt_out)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit h,
                       input bit j, input bit b, input int c,
                       input int sel);
    reset      = r;
    start_in   = s;
    halt_in    = h;
    jump_in    = j;
    branch_in  = b;
    cond_in    = 8'(c);
    target_sel = 5'(sel);
  endtask

  // Advance one clock, update the model from the sampled inputs, compare
  task automatic tick(input string tag);
    int  n_mode, n_pc, n_cnt;
    bit  n_done;
    n_mode = m_mode;
    n_pc   = m_pc;
    n_done = m_done;
    n_cnt  = m_cnt;
    if (reset) begin
      n_mode = 0; n_pc = 0; n_done = 0; n_cnt = 0;
    end else if (m_mode == 0) begin
      n_pc = 0; n_done = 0;
      if (start_in) begin n_mode = 1; n_cnt = 0; end
    end else if (m_mode == 1) begin
      n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (halt_in) begin
        n_mode = 2; n_done = 1;
      end else if (jump_in || (branch_in && cond_in != 0)) begin
        n_pc = lut[target_sel];
      end else begin
        n_pc = (m_pc + 1) % 1024;
      end
    end else begin
      n_done = 1;
      if (start_in) begin
        n_mode = 1; n_pc = 0; n_done = 0; n_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    m_mode = n_mode;
    m_pc   = n_pc;
    m_done = n_done;
    m_cnt  = n_cnt;
    chk({tag, ".pc"}, int'(pc_out), m_pc);
    chk({tag, ".done"}, int'(done_out), int'(m_done));
`ifdef PC_CYCLE_COUNT_EN
    chk({tag, ".cnt"}, int'(cycle_cnt_out), m_cnt);
`endif
  endtask

  initial begin
    foreach (lut[i]) lut[i] = 0;
    lut[1] = 5;  lut[2] = 7;   lut[3] = 40;  lut[4] = 12;
    lut[7] = 1023; lut[9] = 100; lut[17] = 513; lut[31] = 1;
    m_mode = 0; m_pc = 0; m_done = 0; m_cnt = 0;

    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick("reset");
    // idle ignores control
    drive(0, 0, 1, 1, 1, 1, 3);
    tick("idle_ignore");
    chk("idle_pc0", int'(pc_out), 0);

    // start then sequential fetch 0,1,2,3
    drive(0, 1, 0, 0, 0, 0, 0);
    tick("start");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("seq1");
    tick("seq2");
    tick("seq3");
    chk("seq_pc3", int'(pc_out), 3);
    tick("seq4");
    tick("seq5");
    chk("at_pc5", int'(pc_out), 5);

    // taken branch, then not-taken from pc 5
    drive(0, 0, 0, 0, 1, 1, 3);
    tick("br_taken");
    chk("br_to40", int'(pc_out), 40);
    drive(0, 0, 0, 1, 0, 0, 1);
    tick("jmp_to5");
    drive(0, 0, 0, 0, 1, 0, 3);
    tick("br_not");
    chk("br_fall6", int'(pc_out), 6);
    drive(0, 0, 0, 0, 1, 8'h80, 9);
    tick("br_msb");
    chk("br_to100", int'(pc_out), 100);
    drive(0, 1, 0, 1, 1, 0, 17);
    tick("jmp_br_start");

    // jump+halt together at pc 7
    drive(0, 0, 0, 1, 0, 0, 2);
    tick("jmp_to7");
    drive(0, 0, 1, 1, 0, 0, 3);
    tick("halt");
    chk("halt_pc7", int'(pc_out), 7);
    chk("halt_done", int'(done_out), 1);
    drive(0, 0, 0, 1, 1, 1, 3);
    tick("halt_hold");
    drive(0, 1, 0, 0, 0, 0, 0);
    tick("restart");
    chk("restart_done0", int'(done_out), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("resume");

    // wrap at top of address space
    drive(0, 0, 0, 1, 0, 0, 7);
    tick("jmp_1023");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("wrap");
    chk("wrap_pc0", int'(pc_out), 0);
    tick("post_wrap");

    // reset mid-run dominates
    drive(0, 0, 0, 1, 0, 0, 4);
    tick("jmp_12");
    drive(1, 1, 0, 0, 1, 1, 3);
    tick("mid_reset");
    drive(1, 1, 0, 0, 0, 0, 0);
    tick("reset_hold");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("after_reset");
    tick("still_idle");

    // nine RUN cycles, halt sampled in the ninth
    drive(0, 1, 0, 0, 0, 0, 0);
    tick("cnt_start");
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (8) tick("cnt_run");
    drive(0, 0, 1, 0, 0, 0, 0);
    tick("cnt_halt");
    chk("cnt_halt_pc", int'(pc_out), 8);
`ifdef PC_CYCLE_COUNT_EN
    chk("cnt_nine", int'(cycle_cnt_out), 9);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("cnt_hold");
    chk("cnt_frozen", int'(cycle_cnt_out), 9);
    drive(0, 1, 0, 0, 0, 0, 0);
    tick("cnt_restart");
    chk("cnt_clear", int'(cycle_cnt_out), 0);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 255)),
            int'($urandom_range(0, 31)));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
